// File: rtl/reset_sequencer.sv
// reset_sequencer: holds every downstream reset domain in reset for a minimum
// time after a system reset or software request, then releases the domains
// one at a time, lowest index first, with a programmed gap between releases.
//
// Build option:
//   RESET_SEQ_ACK_EN  defined   - each advance also waits for the acknowledge
//                                 of the most recently released domain, and a
//                                 missing acknowledge sets a sticky error flag.
//                     undefined - advances are purely counter-timed, ack_i is
//                                 ignored and error_o is held at 0.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_ASSERT  | every domain in reset, counting the hold time
// ST_RELEASE | domains 0..stage_o-1 released, timing the next advance
// ST_DONE    | all domains released, ready_o high, waiting for a reset
module reset_sequencer #(
    parameter int NUM_DOMAINS  = 4,
    parameter int HOLD_CYCLES  = 8,
    parameter int STAGE_CYCLES = 4,
    parameter int ACK_TIMEOUT  = 64
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               sw_reset_req_i,
    input  logic [NUM_DOMAINS-1:0]             ack_i,
    output logic [NUM_DOMAINS-1:0]             reset_no,
    output logic [$clog2(NUM_DOMAINS+1)-1:0]   stage_o,
    output logic                               ready_o,
    output logic                               error_o
);

    localparam int STAGE_W = $clog2(NUM_DOMAINS + 1);
    // The counter must reach both the hold time and the acknowledge timeout.
    localparam int CNT_MAX = (HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   HOLD_TC   = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0]   STAGE_TC  = CNT_W'(STAGE_CYCLES);
    localparam logic [CNT_W-1:0]   ACK_TC    = CNT_W'(ACK_TIMEOUT);
    localparam logic [STAGE_W-1:0] LAST_STG  = STAGE_W'(NUM_DOMAINS);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic stage_elapsed;
    logic last_stage;
    logic advance;
    logic timeout;

    // Cycle count since the last release edge: cnt equals the number of edges
    // elapsed, so the gap has elapsed once it reaches STAGE_CYCLES.
    assign stage_elapsed = (cnt >= STAGE_TC);
    assign last_stage    = (stage_o == LAST_STG);

`ifdef RESET_SEQ_ACK_EN
    logic ack_cur;

    // Select the acknowledge of the domain released most recently.
    always_comb begin
        ack_cur = 1'b0;
        for (int k = 0; k < NUM_DOMAINS; k++) begin
            if (stage_o == STAGE_W'(k + 1)) begin
                ack_cur = ack_i[k];
            end
        end
    end

    assign advance = stage_elapsed && ack_cur;
    // cnt saturates at ACK_TIMEOUT, so this also re-fires harmlessly on every
    // later edge; the flag is sticky anyway.
    assign timeout = (cnt == ACK_TC) && !advance;
`else
    logic unused_ack;

    assign unused_ack = ^ack_i;
    assign advance    = stage_elapsed;
    assign timeout    = 1'b0;
`endif

    // Sequencer FSM with registered outputs; a reset or request restarts the
    // whole sequence on the same edge from any state.
    always_ff @(posedge clk_i) begin
        if (reset_i || sw_reset_req_i) begin
            state    <= ST_ASSERT;
            cnt      <= '0;
            reset_no <= '0;
            stage_o  <= '0;
            ready_o  <= 1'b0;
            error_o  <= 1'b0;
        end else begin
            case (state)
                ST_ASSERT: begin
                    if (cnt == HOLD_TC) begin
                        reset_no <= NUM_DOMAINS'(1);
                        stage_o  <= STAGE_W'(1);
                        cnt      <= CNT_W'(1);
                        state    <= ST_RELEASE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (advance) begin
                        if (last_stage) begin
                            ready_o <= 1'b1;
                            state   <= ST_DONE;
                        end else begin
                            reset_no <= (reset_no << 1) | NUM_DOMAINS'(1);
                            stage_o  <= stage_o + STAGE_W'(1);
                            cnt      <= CNT_W'(1);
                        end
                    end else begin
                        if (cnt != ACK_TC) begin
                            cnt <= cnt + CNT_W'(1);
                        end
                        if (timeout) begin
                            error_o <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_ASSERT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios followed by random reset,
// request and acknowledge traffic, compared every cycle against a model that
// works in terms of absolute release edge numbers.
module tb_reset_sequencer;

    localparam int ND      = 4;
    localparam int HOLD    = 8;
    localparam int STAGE   = 4;
    localparam int ACK_TO  = 64;
    localparam int STAGE_W = $clog2(ND + 1);
`ifdef RESET_SEQ_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    logic               clk_i = 1'b0;
    logic               reset_i = 1'b1;
    logic               sw_reset_req_i = 1'b0;
    logic [ND-1:0]      ack_i = '0;
    logic [ND-1:0]      reset_no;
    logic [STAGE_W-1:0] stage_o;
    logic               ready_o;
    logic               error_o;

    int n_checks = 0;
    int n_pass   = 0;

    // model state: edge number, edge of E0, domains released, last release edge
    int cyc      = 0;
    bit m_in_rst = 1'b1;
    int m_e0     = 0;
    int m_nrel   = 0;
    int m_last   = 0;
    bit m_ready  = 1'b0;
    bit m_err    = 1'b0;

    reset_sequencer #(
        .NUM_DOMAINS (ND),
        .HOLD_CYCLES (HOLD),
        .STAGE_CYCLES(STAGE),
        .ACK_TIMEOUT (ACK_TO)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .sw_reset_req_i(sw_reset_req_i),
        .ack_i         (ack_i),
        .reset_no      (reset_no),
        .stage_o       (stage_o),
        .ready_o       (ready_o),
        .error_o       (error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic model_edge(input logic r, input logic q, input logic [ND-1:0] a);
        logic [ND-1:0] a_eff;
        a_eff = ACK_EN ? a : '1;
        cyc++;
        if (r || q) begin
            m_in_rst = 1'b1;
            m_nrel   = 0;
            m_ready  = 1'b0;
            m_err    = 1'b0;
        end else begin
            if (m_in_rst) begin
                m_in_rst = 1'b0;
                m_e0     = cyc;
            end
            if (m_nrel == 0) begin
                if (cyc == m_e0 + HOLD) begin
                    m_nrel = 1;
                    m_last = cyc;
                end
            end else if (!m_ready) begin
                if ((cyc - m_last) >= STAGE && a_eff[m_nrel-1]) begin
                    if (m_nrel == ND) begin
                        m_ready = 1'b1;
                    end else begin
                        m_nrel++;
                        m_last = cyc;
                    end
                end else if (ACK_EN && (cyc - m_last) == ACK_TO) begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic q, input logic [ND-1:0] a);
        logic [ND-1:0] exp_rn;
        reset_i        = r;
        sw_reset_req_i = q;
        ack_i          = a;
        @(posedge clk_i);
        model_edge(r, q, a);
        #1;
        exp_rn = '0;
        for (int k = 0; k < ND; k++) begin
            if (k < m_nrel) exp_rn[k] = 1'b1;
        end
        n_checks++;
        assert (reset_no === exp_rn) n_pass++;
        else $error("FAIL reset_no cyc=%0d got=%b exp=%b", cyc, reset_no, exp_rn);
        n_checks++;
        assert (stage_o === STAGE_W'(m_nrel)) n_pass++;
        else $error("FAIL stage_o cyc=%0d got=%0d exp=%0d", cyc, stage_o, m_nrel);
        n_checks++;
        assert (ready_o === m_ready) n_pass++;
        else $error("FAIL ready_o cyc=%0d got=%b exp=%b", cyc, ready_o, m_ready);
        n_checks++;
        assert (error_o === m_err) n_pass++;
        else $error("FAIL error_o cyc=%0d got=%b exp=%b", cyc, error_o, m_err);
    endtask

    initial begin
        // power-up: reset for 3 cycles, then run the full sequence into DONE
        repeat (3) step(1'b1, 1'b0, '0);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, '1);

        // mid-sequence request at E0+14 (stage 2)
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < 14; i++) step(1'b0, 1'b0, '1);
        step(1'b0, 1'b1, '1);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, '1);

        // held request for 20 cycles while in DONE, then release resumes
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, '1);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, '1);

        // acknowledge of domain 0 arrives at E0+20
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, (i >= 20) ? 4'b1111 : 4'b0000);

        // acknowledge never arrives: timeout at E0+72, then reset clears it
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < 80; i++) step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, '0);

        // reset and request together, acks high during the hold
        step(1'b1, 1'b1, '1);
        step(1'b1, 1'b1, '1);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, '1);

        // random reset/request/ack traffic
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                 ND'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
